// File: rtl/fetch_pc_ctrl.sv
// rtl/fetch_pc_ctrl.sv - instruction fetch stage and program counter owner
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   pc_branch_sel, branch_target taken-branch redirect from Branch_logic
//   stall                       decode does not consume while high
//   halt_req, resume            enter / leave the parked HALT state
//   imem_req, imem_addr         fetch request and word address
//   imem_rdy, imem_rdata        memory response handshake and instruction
//   if_instr, if_pc, if_valid   instruction presented to decode
//   flush                       one-cycle squash pulse after a redirect
//   halted                      fetch is parked
module fetch_pc_ctrl #(
    parameter int                ADDR_W   = 16,
    parameter int                INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pc_branch_sel,
    input  logic [ADDR_W-1:0]  branch_target,
    input  logic               stall,
    input  logic               halt_req,
    input  logic               resume,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_rdy,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] if_instr,
    output logic [ADDR_W-1:0]  if_pc,
    output logic               if_valid,
    output logic               flush,
    output logic               halted
);
    localparam logic [1:0] ST_FETCH   = 2'd0;
    localparam logic [1:0] ST_DISCARD = 2'd1;
    localparam logic [1:0] ST_HALT    = 2'd2;
    localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

    logic [1:0]         state, state_n;
    logic [ADDR_W-1:0]  pc, pc_n;
    logic               pending;
    logic               halt_lat, halt_lat_n;
    logic               skid_valid, skid_valid_n;
    logic [INSTR_W-1:0] skid_instr, skid_instr_n;
    logic [ADDR_W-1:0]  skid_pc, skid_pc_n;
    logic               if_valid_n;
    logic [INSTR_W-1:0] if_instr_n;
    logic [ADDR_W-1:0]  if_pc_n;
    logic               flush_n;
    logic               done;
    logic               waiting;

    // rst_n gates the request so the bus is quiet for the whole reset window.
    assign imem_req = rst_n && (pending ||
                      ((state == ST_FETCH) && !(stall && if_valid) && !skid_valid));
    assign done     = imem_req && imem_rdy;
    assign waiting  = imem_req && !imem_rdy;
    assign halted   = (state == ST_HALT);

    always_comb begin
        state_n      = state;
        pc_n         = pc;
        halt_lat_n   = halt_lat;
        skid_valid_n = skid_valid;
        skid_instr_n = skid_instr;
        skid_pc_n    = skid_pc;
        if_valid_n   = if_valid;
        if_instr_n   = if_instr;
        if_pc_n      = if_pc;
        flush_n      = 1'b0;
        case (state)
            ST_FETCH, ST_DISCARD: begin
                if (pc_branch_sel) begin
                    // Any response completing now is wrong-path; one still
                    // outstanding must be drained before fetching the target.
                    pc_n         = branch_target;
                    if_valid_n   = 1'b0;
                    skid_valid_n = 1'b0;
                    flush_n      = 1'b1;
                    halt_lat_n   = 1'b0;
                    state_n      = waiting ? ST_DISCARD : ST_FETCH;
                end else if (state == ST_DISCARD) begin
                    if (done) begin
                        state_n = halt_lat ? ST_HALT : ST_FETCH;
                    end
                end else if (halt_req) begin
                    // Everything behind the HALT is dropped; pc must point at
                    // HALT+1, which is the skid entry if one is parked there.
                    if_valid_n   = 1'b0;
                    skid_valid_n = 1'b0;
                    if (skid_valid) begin
                        pc_n = skid_pc;
                    end
                    if (waiting) begin
                        halt_lat_n = 1'b1;
                        state_n    = ST_DISCARD;
                    end else begin
                        state_n = ST_HALT;
                    end
                end else if (done) begin
                    pc_n = pc + PC_ONE;
                    if (!if_valid || !stall) begin
                        if_valid_n = 1'b1;
                        if_instr_n = imem_rdata;
                        if_pc_n    = imem_addr;
                    end else begin
                        skid_valid_n = 1'b1;
                        skid_instr_n = imem_rdata;
                        skid_pc_n    = imem_addr;
                    end
                end else if (if_valid && !stall) begin
                    if (skid_valid) begin
                        if_instr_n   = skid_instr;
                        if_pc_n      = skid_pc;
                        skid_valid_n = 1'b0;
                    end else begin
                        if_valid_n = 1'b0;
                    end
                end
            end
            ST_HALT: begin
                if (resume) begin
                    state_n    = ST_FETCH;
                    halt_lat_n = 1'b0;
                end
            end
            default: state_n = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_FETCH;
            pc         <= RESET_PC;
            imem_addr  <= RESET_PC;
            pending    <= 1'b0;
            halt_lat   <= 1'b0;
            skid_valid <= 1'b0;
            skid_instr <= '0;
            skid_pc    <= '0;
            if_valid   <= 1'b0;
            if_instr   <= '0;
            if_pc      <= '0;
            flush      <= 1'b0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            pending    <= waiting;
            halt_lat   <= halt_lat_n;
            skid_valid <= skid_valid_n;
            skid_instr <= skid_instr_n;
            skid_pc    <= skid_pc_n;
            if_valid   <= if_valid_n;
            if_instr   <= if_instr_n;
            if_pc      <= if_pc_n;
            flush      <= flush_n;
            // The address bus holds the in-flight request, which may differ
            // from pc while a wrong-path response is being drained.
            if (!waiting) begin
                imem_addr <= pc_n;
            end
        end
    end
endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// tb/tb_fetch_pc_ctrl.sv - randomized self-checking bench for fetch_pc_ctrl
module tb_fetch_pc_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pc_branch_sel = 1'b0;
    logic [15:0] branch_target = '0;
    logic        stall = 1'b0;
    logic        halt_req = 1'b0;
    logic        resume = 1'b0;
    logic        imem_rdy = 1'b0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] if_instr;
    logic [15:0] if_pc;
    logic        if_valid, flush, halted;

    logic        w_imem_req;
    logic [15:0] w_imem_addr;
    logic [31:0] w_imem_rdata, w_if_instr;
    logic [15:0] w_if_pc;
    logic        w_if_valid, w_flush, w_halted;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_cons = 0;
    logic [15:0] exp_pc = '0;
    logic        m_halted = 1'b0;
    logic        prev_wait = 1'b0;
    logic [15:0] prev_addr = '0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        return {a ^ 16'h5A3C, ~a};
    endfunction

    assign imem_rdata   = mem_word(imem_addr);
    assign w_imem_rdata = mem_word(w_imem_addr);

    fetch_pc_ctrl #(.ADDR_W(16), .INSTR_W(32), .RESET_PC(16'h0000)) u_dut (
        .clk(clk), .rst_n(rst_n), .pc_branch_sel(pc_branch_sel),
        .branch_target(branch_target), .stall(stall), .halt_req(halt_req),
        .resume(resume), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdy(imem_rdy), .imem_rdata(imem_rdata), .if_instr(if_instr),
        .if_pc(if_pc), .if_valid(if_valid), .flush(flush), .halted(halted)
    );

    fetch_pc_ctrl #(.ADDR_W(16), .INSTR_W(32), .RESET_PC(16'hFFFE)) u_wrap (
        .clk(clk), .rst_n(rst_n), .pc_branch_sel(1'b0),
        .branch_target(16'h0000), .stall(1'b0), .halt_req(1'b0),
        .resume(1'b0), .imem_req(w_imem_req), .imem_addr(w_imem_addr),
        .imem_rdy(1'b1), .imem_rdata(w_imem_rdata), .if_instr(w_if_instr),
        .if_pc(w_if_pc), .if_valid(w_if_valid), .flush(w_flush), .halted(w_halted)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // One clock cycle: drive at posedge+1, judge the coming edge, check after it.
    task automatic step(input logic s, input logic r, input logic br,
                        input logic [15:0] tgt, input logic h, input logic res);
        logic redir;
        stall = s; imem_rdy = r; pc_branch_sel = br; branch_target = tgt;
        halt_req = h; resume = res;
        #1;
        if (prev_wait) begin
            check("req_hold", 32'(imem_req), 32'd1);
            check("addr_hold", 32'(imem_addr), 32'(prev_addr));
        end
        if (m_halted) check("halted_ifv", 32'(if_valid), 32'd0);
        if (if_valid && !s) begin
            check("if_pc", 32'(if_pc), 32'(exp_pc));
            check("if_instr", if_instr, mem_word(exp_pc));
            exp_pc = exp_pc + 16'd1;
            n_cons++;
        end
        redir = br && !m_halted;
        if (redir) exp_pc = tgt;
        if (h && !br && !m_halted) m_halted = 1'b1;
        else if (res) m_halted = 1'b0;
        prev_wait = imem_req && !r;
        prev_addr = imem_addr;
        @(posedge clk);
        #1;
        check("flush", 32'(flush), 32'(redir));
    endtask

    task automatic do_reset();
        rst_n = 1'b0; stall = 0; imem_rdy = 0; pc_branch_sel = 0;
        halt_req = 0; resume = 0; branch_target = '0;
        #1;
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_valid", 32'(if_valid), 32'd0);
        check("rst_pc", 32'(if_pc), 32'd0);
        check("rst_instr", if_instr, 32'd0);
        check("rst_flush", 32'(flush), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_addr", 32'(imem_addr), 32'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        exp_pc = 16'h0000; m_halted = 1'b0; prev_wait = 1'b0;
    endtask

    task automatic do_halt();
        int k;
        k = 0;
        while (!halted && k < 40) begin
            step($urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0, 1'b0, 16'h0, 1'b0, 1'b0);
            k++;
        end
        check("halt_enter", 32'(halted), 32'd1);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, i == 2, 16'hBEEF, 1'b0, 1'b0);
            check("halt_req_off", 32'(imem_req), 32'd0);
            check("halt_hold", 32'(halted), 32'd1);
        end
        step(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
        check("resume", 32'(halted), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        s, r, br, h;
        logic [15:0] tgt;
        int          c0;

        // Straight-line fetch from reset, plus the wrapping instance.
        do_reset();
        #1;
        check("t1_req", 32'(imem_req), 32'd1);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
            check("t1_addr", 32'(imem_addr), 32'(i + 1));
            check("t1_valid", 32'(if_valid), 32'd1);
            check("wrap_valid", 32'(w_if_valid), 32'd1);
            check("wrap_pc", 32'(w_if_pc), 32'(16'(32'hFFFE + i)));
        end

        // Redirect while 0x0005 completes.
        step(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 16'h0040, 1'b0, 1'b0);
        check("t2_valid", 32'(if_valid), 32'd0);
        step(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
        check("t2_pc", 32'(if_pc), 32'h40);
        step(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
        check("t2_pc_next", 32'(if_pc), 32'h41);

        // Stall holding 0x0002 while memory is slow at 0x0003.
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            step(1'b1, k >= 3, 1'b0, 16'h0, 1'b0, 1'b0);
            check("t3_hold_pc", 32'(if_pc), 32'h2);
            check("t3_hold_valid", 32'(if_valid), 32'd1);
            check("t3_addr", 32'(imem_addr), 32'h3);
        end
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);

        // Redirect during an outstanding fetch, then reset mid-wait.
        step(1'b0, 1'b1, 1'b1, 16'h0010, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 16'h0080, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
            check("t4_addr", 32'(imem_addr), 32'h10);
        end
        step(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
        check("t4_drop", 32'(if_valid), 32'd0);
        step(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
        check("t4_pc", 32'(if_pc), 32'h80);
        step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        check("t4_wait_req", 32'(imem_req), 32'd1);
        do_reset();
        step(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
        check("t4_restart", 32'(if_pc), 32'h0);

        // HALT at 0x0020, resume, then same-edge halt and redirect.
        step(1'b0, 1'b1, 1'b1, 16'h001E, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
        check("t5_at_halt", 32'(if_pc), 32'h20);
        step(1'b0, 1'b1, 1'b0, 16'h0, 1'b1, 1'b0);
        do_halt();
        step(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
        check("t5_after", 32'(if_pc), 32'h21);
        step(1'b0, 1'b1, 1'b1, 16'h0030, 1'b1, 1'b0);
        check("t5_no_halt", 32'(halted), 32'd0);
        step(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
        check("t5_redir", 32'(if_pc), 32'h30);

        // Randomized traffic against the reference model.
        c0 = n_cons;
        for (int c = 0; c < 1500; c++) begin
            s   = $urandom_range(0, 9) < 3;
            r   = $urandom_range(0, 9) < 7;
            br  = $urandom_range(0, 24) == 0;
            tgt = 16'($urandom);
            h   = if_valid && !s && !br && ($urandom_range(0, 39) == 0);
            step(s, r, br, tgt, h, 1'b0);
            if (h) do_halt();
        end
        check("liveness", 32'(n_cons - c0 > 200), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fetch_pc_ctrl.md
Name: fetch_pc_ctrl

Overview:
Instruction-fetch stage and program counter owner. It sits directly downstream of Branch_logic and consumes its registered pc_branch_sel_out together with the resolved branch target. It issues word addresses to instruction memory over a req/rdy handshake and presents fetched instructions to decode with a valid flag. It handles branch redirect and wrong-path flush, hazard stalls (through a one-entry skid buffer), and halt/resume.

Parameters:
ADDR_W, 16, PC and instruction-memory word-address width
INSTR_W, 32, instruction width
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  system clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
pc_branch_sel  in  1  taken-branch pulse from Branch_logic, sampled on clk edge
branch_target  in  ADDR_W  redirect address, valid while pc_branch_sel=1
stall  in  1  hazard-unit stall; decode does not consume while high
halt_req  in  1  decode detected HALT, sampled on clk edge
resume  in  1  leave HALT state
imem_req  out  1  fetch request
imem_addr  out  ADDR_W  fetch word address
imem_rdy  in  1  memory response; transfer completes on an edge with imem_req=1 and imem_rdy=1
imem_rdata  in  INSTR_W  instruction, valid with imem_rdy
if_instr  out  INSTR_W  instruction to decode
if_pc  out  ADDR_W  address of if_instr
if_valid  out  1  if_instr/if_pc valid; consumed on edge with if_valid=1 and stall=0
flush  out  1  one-cycle squash pulse to downstream stages
halted  out  1  fetch is parked in HALT

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, state=FETCH, pending=0, skid empty, if_valid=0, if_instr=0, if_pc=0, flush=0, halted=0. Outputs go to these values immediately, including mid-transfer. No response is carried across reset.
- States:
  - FETCH: normal operation.
  - DISCARD: drain one outstanding wrong-path response.
  - HALT: parked.
- imem_addr = pc, registered. It must stay stable while imem_req=1 and the transfer has not completed.
- pending: set when imem_req=1 and imem_rdy=0 at an edge; cleared on completion.
- imem_req = pending OR (state=FETCH AND NOT (stall AND if_valid) AND skid empty). Once asserted, imem_req is never dropped before completion.
- Completion in FETCH:
  - pc <= pc+1, modulo 2^ADDR_W (0xFFFF wraps to 0x0000 at ADDR_W=16).
  - If the output register is free (if_valid=0 or stall=0): if_instr <= imem_rdata, if_pc <= pc, if_valid <= 1.
  - Otherwise the data is written to the skid buffer.
- Consume edge (if_valid=1, stall=0) with no new completion:
  - If the skid is full, the skid moves to the output register and the skid is cleared.
  - Else if_valid <= 0.
- Throughput: with imem_rdy tied high and stall low, one instruction per cycle. Latency is 1 cycle from request to if_valid.
- Redirect: pc_branch_sel=1 at an edge in FETCH or DISCARD:
  - pc <= branch_target; if_valid <= 0; skid cleared; flush=1 for exactly the next cycle.
  - If a response is outstanding (pending=1 and no completion this edge), go to DISCARD.
  - A completion on the same edge as the redirect is discarded and pc takes branch_target, not pc+1.
  - Redirect has priority over stall and halt_req.
- DISCARD:
  - imem_req stays asserted at the old address. The response is dropped with no if_valid and no pc change.
  - Return to FETCH, or go to HALT if a halt is latched.
  - A second redirect while in DISCARD overwrites pc and stays in DISCARD.
- Halt: halt_req=1 (with no redirect) in FETCH:
  - Latch the halt; issue no new requests.
  - If pending, go through DISCARD first; else go to HALT next edge.
  - The outstanding or completing instruction (HALT+1) is discarded and pc is not incremented for it, so pc = HALT address + 1.
- HALT state:
  - halted=1, imem_req=0, if_valid=0.
  - resume=1 returns to FETCH, fetching from pc.
  - pc_branch_sel is ignored in HALT.
- flush is 0 in every cycle not following a redirect edge.

Test Plan:
1. Reset release, imem_rdy=1, stall=0, RESET_PC=0 -> imem_addr 0,1,2,3 on consecutive cycles; if_valid high from 1st edge after release; if_pc 0,1,2 back-to-back; flush=0 throughout.
2. Fetching 0x0005 with rdy=1, then pc_branch_sel=1, branch_target=0x0040 -> flush=1 one cycle; if_valid=0 that cycle; next if_pc=0x0040, then 0x0041.
3. imem_rdy low 3 cycles at 0x0003 while stall=1 for 4 cycles, with if_valid=1 holding 0x0002 -> imem_addr held at 0x0003, imem_req held; 0x0003 lands in the skid; after stall drops, if_pc 0x0002 then 0x0003 then 0x0004, none lost or duplicated.
4. imem_rdy low 3 cycles at 0x0010, redirect to 0x0080 in the 1st wait cycle -> imem_req stays at 0x0010 until rdy; that response is dropped; next if_pc=0x0080. Also apply rst_n=0 mid-wait -> imem_req=0, if_valid=0 immediately, restart at RESET_PC.
5. halt_req at HALT address 0x0020 -> halted=1, imem_req=0, and if_valid=0 while halted; resume after 5 cycles -> next if_pc=0x0021. Same-edge halt_req and pc_branch_sel (target 0x0030) -> no halt, next if_pc=0x0030.
6. RESET_PC=0xFFFE, ADDR_W=16, rdy=1 -> if_pc 0xFFFE, 0xFFFF, 0x0000, 0x0001.
